ysyx_25040111_mem_arbiter: RTL
==============================

YSYX_25040111_MEM_ARBITER -- requirements
Module: ysyx_25040111_mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_MST, 2, number of requesting masters (2..8); AW, 32, address width; DW, 32, data width; LEN_W, 8, burst-length field width; RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  N_MST  per-master request valid.
REQ-005 req_ready  output  N_MST  per-master request accepted (one-hot or zero).
REQ-006 req_write  input  N_MST  per-master 1 = write, 0 = read.
REQ-007 req_addr  input  N_MST*AW  per-master address; master i occupies slice [i*AW +: AW].
REQ-008 req_wdata  input  N_MST*DW  per-master write data.
REQ-009 req_mask  input  N_MST*2  per-master size code: 0 = byte, 1 = half, 2 = word.
REQ-010 req_rsign  input  N_MST  per-master sign-extend flag for reads.
REQ-011 req_len  input  N_MST*LEN_W  per-master beats minus one; reads only, writes treat it as 0.
REQ-012 resp_valid  output  N_MST  per-master response beat valid.
REQ-013 resp_data  output  DW  response data, shared by all masters.
REQ-014 resp_last  output  1  final beat of the current transaction.
REQ-015 resp_err  output  1  protocol error on the current beat.
REQ-016 mem_req_valid / mem_req_ready  output / input  1 / 1  downstream request handshake.
REQ-017 mem_write, mem_addr, mem_wdata, mem_mask, mem_rsign, mem_len  output  1 / AW / DW / 2 / 1 / LEN_W  latched request fields.
REQ-018 mem_resp_valid, mem_resp_data, mem_resp_last  input  1 / DW / 1  downstream response beat; no backpressure is applied to it.
REQ-019 grant_id  output  3  index of the current owner; valid while busy.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-021 IDLE, when any req_valid is set:
- select a winner combinationally;
- assert req_ready[winner] for that cycle;
- latch the winner's fields and grant_id;
- go to ISSUE on the next edge.
REQ-022 Winner selection, RR_MODE=1: the first set req_valid searching upward from rr_ptr, modulo N_MST.
REQ-023 Winner selection, RR_MODE=0: the lowest set index.
REQ-024 ISSUE SHALL hold mem_req_valid=1 with stable latched fields until mem_req_ready=1, then go to RESP and load beat_cnt=0.
REQ-025 mem_req_valid SHALL be 0 in every state other than ISSUE.
REQ-026 RESP, on each mem_resp_valid:
- resp_valid[grant_id]=1 in the same cycle (combinational pass-through);
- resp_data=mem_resp_data;
- beat_cnt increments.
REQ-027 Expected final beat SHALL be beat_cnt == mem_len for reads and the first beat for writes.
REQ-028 resp_last SHALL be asserted on the expected final beat, and the FSM SHALL return to IDLE on the next edge.
REQ-029 Early mem_resp_last (before the expected final beat) SHALL:
- assert resp_err and resp_last on that beat;
- end the transaction (return to IDLE).
REQ-030 Missing mem_resp_last on the expected final beat SHALL assert resp_err while the transaction still ends on count.
REQ-031 On completion in RR_MODE, rr_ptr SHALL become grant_id+1, wrapping from N_MST-1 to 0.
REQ-032 A request arriving in the completion cycle SHALL NOT be granted until the following IDLE cycle (one-cycle bubble).
REQ-033 Requests SHALL never be granted outside IDLE.
REQ-034 A master SHALL hold req_valid and its fields until req_ready; deasserting earlier discards the request with no side effect.
REQ-035 beat_cnt SHALL be LEN_W bits wide.
REQ-036 A read with req_len = 2^LEN_W-1 SHALL complete after exactly 2^LEN_W beats, with no wrap-induced early termination.

Reset
REQ-037 While reset=1, regardless of clock:
- state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0;
- all latched fields 0;
- req_ready, resp_valid, resp_last, resp_err and mem_req_valid all 0.
REQ-038 Reset asserted mid-ISSUE or mid-RESP SHALL abandon the transaction.
REQ-039 After such a reset, beats still arriving on mem_resp_valid SHALL be ignored until the next ISSUE.

Verification
REQ-040 N_MST=2, RR_MODE=1, both masters request continuously -> grants alternate 0,1,0,1 with one IDLE bubble between transactions.
REQ-041 RR_MODE=0, masters 0 and 1 request continuously -> master 1 is never granted while master 0 stays valid.
REQ-042 Read by master 1 with len=3, mem_resp_last on the 4th beat -> resp_valid[1] pulses 4 times, resp_last only on the 4th, resp_err=0.
REQ-043 Read with len=3, mem_resp_last on the 2nd beat -> resp_err=1 and resp_last=1 on beat 2, FSM in IDLE next cycle.
REQ-044 Write with mem_req_ready low for 5 cycles -> mem_req_valid and fields stable for 5 cycles; one response beat with resp_last=1.
REQ-045 Reset pulsed during RESP of a len=7 read -> all outputs 0 immediately, later beats produce no resp_valid, and the next grant is master 0.

Source files
------------

// File: rtl/ysyx_25040111_mem_arbiter.sv
// N-master to single-memory arbiter with round-robin or fixed priority,
// one outstanding transaction at a time and read bursts of up to 2^LEN_W beats.
//
// Handshake rules: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both high. The master must hold req_valid and its fields
// until then. mem_req_valid is held with stable fields until mem_req_ready.
// Response beats (mem_resp_valid) cannot be back-pressured.
module ysyx_25040111_mem_arbiter #(
  parameter int N_MST   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LEN_W   = 8,
  parameter int RR_MODE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_MST-1:0]       req_valid,
  output logic [N_MST-1:0]       req_ready,
  input  logic [N_MST-1:0]       req_write,
  input  logic [N_MST*AW-1:0]    req_addr,
  input  logic [N_MST*DW-1:0]    req_wdata,
  input  logic [N_MST*2-1:0]     req_mask,
  input  logic [N_MST-1:0]       req_rsign,
  input  logic [N_MST*LEN_W-1:0] req_len,
  output logic [N_MST-1:0]       resp_valid,
  output logic [DW-1:0]          resp_data,
  output logic                   resp_last,
  output logic                   resp_err,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_write,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic [1:0]             mem_mask,
  output logic                   mem_rsign,
  output logic [LEN_W-1:0]       mem_len,
  input  logic                   mem_resp_valid,
  input  logic [DW-1:0]          mem_resp_data,
  input  logic                   mem_resp_last,
  output logic [2:0]             grant_id,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e           state_q;
  logic [2:0]       rr_ptr_q;
  logic [2:0]       grant_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic             mem_write_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;
  logic [1:0]       mem_mask_q;
  logic             mem_rsign_q;
  logic [LEN_W-1:0] mem_len_q;

  logic             win_found;
  logic [2:0]       win_idx;
  int               base;
  int               cand;
  logic             sel_write;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic [1:0]       sel_mask;
  logic             sel_rsign;
  logic [LEN_W-1:0] sel_len;

  logic             beat;
  logic             exp_last;
  logic             done;
  logic [2:0]       next_ptr;

  // Winner search starting at rr_ptr (or 0 in fixed mode), then field mux.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    base      = (RR_MODE != 0) ? int'(rr_ptr_q) : 0;
    cand      = 0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    sel_rsign = 1'b0;
    sel_len   = '0;
    for (int k = 0; k < N_MST; k++) begin
      cand = base + k;
      if (cand >= N_MST) cand = cand - N_MST;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
    for (int i = 0; i < N_MST; i++) begin
      if (win_idx == 3'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_mask  = req_mask[i*2 +: 2];
        sel_rsign = req_rsign[i];
        // Writes are always single-beat regardless of the length field.
        sel_len   = req_write[i] ? '0 : req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Beat classification: final beat is by count, mem_resp_last only cross-checks it.
  always_comb begin
    beat      = (state_q == S_RESP) && mem_resp_valid;
    exp_last  = mem_write_q || (beat_cnt_q == mem_len_q);
    done      = beat && (exp_last || mem_resp_last);
    resp_last = done;
    resp_err  = beat && (exp_last != mem_resp_last);
    next_ptr  = (grant_q == 3'(N_MST - 1)) ? 3'd0 : grant_q + 3'd1;
    for (int i = 0; i < N_MST; i++) begin
      req_ready[i]  = !reset && (state_q == S_IDLE) && win_found && (win_idx == 3'(i));
      resp_valid[i] = beat && (grant_q == 3'(i));
    end
  end

  assign resp_data     = mem_resp_data;
  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_mask      = mem_mask_q;
  assign mem_rsign     = mem_rsign_q;
  assign mem_len       = mem_len_q;
  assign grant_id      = grant_q;
  assign dbg_state     = state_q;

  // Arbitration FSM: grant in IDLE, hold request in ISSUE, count beats in RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 3'd0;
      grant_q     <= 3'd0;
      beat_cnt_q  <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_rsign_q <= 1'b0;
      mem_len_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q     <= S_ISSUE;
            grant_q     <= win_idx;
            mem_write_q <= sel_write;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_mask_q  <= sel_mask;
            mem_rsign_q <= sel_rsign;
            mem_len_q   <= sel_len;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            state_q    <= S_RESP;
            beat_cnt_q <= '0;
          end
        end
        S_RESP: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (done) begin
              state_q <= S_IDLE;
              if (RR_MODE != 0) rr_ptr_q <= next_ptr;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
